// File: rtl/addsub_disp_pkg.sv
// Shared constants for the adder/subtractor result display: digit indices,
// active-low seven-segment codes {g,f,e,d,c,b,a}, BCD widths and conversion length.
package addsub_disp_pkg;

  localparam int NUM_DIGITS = 3;
  localparam int BCD_W      = 4;
  localparam int BIN_W      = 5;
  localparam int SHIFT_W    = 2 * BCD_W + BIN_W;
  localparam int CONV_ITERS = BIN_W;

  typedef logic [1:0] dig_idx_t;

  localparam dig_idx_t DIG_ONES = 2'd0;
  localparam dig_idx_t DIG_TENS = 2'd1;
  localparam dig_idx_t DIG_SIGN = 2'd2;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {
    ST_IDLE,
    ST_CONV
  } conv_state_t;

  // One double-dabble iteration: add 3 to any nibble >= 5, then shift left.
  function automatic logic [SHIFT_W-1:0] dabble_step(input logic [SHIFT_W-1:0] sh);
    logic [SHIFT_W-1:0] t;
    t = sh;
    if (t[BIN_W +: BCD_W] >= 4'd5)
      t[BIN_W +: BCD_W] = t[BIN_W +: BCD_W] + 4'd3;
    if (t[BIN_W+BCD_W +: BCD_W] >= 4'd5)
      t[BIN_W+BCD_W +: BCD_W] = t[BIN_W+BCD_W +: BCD_W] + 4'd3;
    return {t[SHIFT_W-2:0], 1'b0};
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-low seven-segment decoder; 10..15 blank.
module bcd_to_seg7
  import addsub_disp_pkg::*;
(
  input  logic [BCD_W-1:0] bcd,
  output logic [6:0]       seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/addsub_result_display.sv
// Captures S/sign on load, converts to BCD over 5 cycles, scans 3 common-anode digits.
// BLANK_LEADING_ZERO_EN: when defined, a zero tens digit is shown blank.
module addsub_result_display
  import addsub_disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [BIN_W-1:0]      S,
  input  logic                  sign,
  output logic                  busy,
  output logic [6:0]            seg,
  output logic                  dp_n,
  output logic [NUM_DIGITS-1:0] an
);

  localparam logic [19:0] SCAN_TC  = 20'(REFRESH_DIV - 1);
  localparam logic [2:0]  ITER_END = 3'(CONV_ITERS - 1);

  conv_state_t          state_q, state_d;
  logic [2:0]           iter_q;
  logic [SHIFT_W-1:0]   sh_q, sh_nxt;
  logic                 neg_pend_q;
  logic [BCD_W-1:0]     tens_q, ones_q;
  logic                 neg_q;
  logic [19:0]          scan_q;
  dig_idx_t             dig_q, dig_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]           seg_q, seg_d;
  logic [6:0]           ones_seg, tens_seg;
  logic                 accept, last_iter;

  assign accept    = (state_q == ST_IDLE) && load;
  assign last_iter = (state_q == ST_CONV) && (iter_q == ITER_END);
  assign sh_nxt    = dabble_step(sh_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (load) state_d = ST_CONV;
      ST_CONV: if (iter_q == ITER_END) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      iter_q     <= '0;
      sh_q       <= '0;
      neg_pend_q <= 1'b0;
      tens_q     <= '0;
      ones_q     <= '0;
      neg_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        sh_q       <= {{(2*BCD_W){1'b0}}, S};
        neg_pend_q <= sign & (S != '0);
        iter_q     <= '0;
      end else if (state_q == ST_CONV) begin
        sh_q   <= sh_nxt;
        iter_q <= iter_q + 3'd1;
      end
      // Display registers only ever see a finished conversion.
      if (last_iter) begin
        tens_q <= sh_nxt[BIN_W+BCD_W +: BCD_W];
        ones_q <= sh_nxt[BIN_W +: BCD_W];
        neg_q  <= neg_pend_q;
      end
    end
  end

  bcd_to_seg7 u_ones_dec (.bcd(ones_q), .seg(ones_seg));
  bcd_to_seg7 u_tens_dec (.bcd(tens_q), .seg(tens_seg));

  always_comb begin
    dig_d = dig_q;
    if (scan_q == SCAN_TC)
      dig_d = (dig_q == DIG_SIGN) ? DIG_ONES : dig_idx_t'(dig_q + 2'd1);
  end

  // an/seg are computed from the upcoming index so both move on the same edge.
  always_comb begin
    an_d  = 3'b111;
    seg_d = SEG_BLANK;
    case (dig_d)
      DIG_ONES: begin
        an_d  = 3'b110;
        seg_d = ones_seg;
      end
      DIG_TENS: begin
        an_d  = 3'b101;
`ifdef BLANK_LEADING_ZERO_EN
        seg_d = (tens_q == '0) ? SEG_BLANK : tens_seg;
`else
        seg_d = tens_seg;
`endif
      end
      DIG_SIGN: begin
        an_d  = 3'b011;
        seg_d = neg_q ? SEG_MINUS : SEG_BLANK;
      end
      default: begin
        an_d  = 3'b111;
        seg_d = SEG_BLANK;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_q <= '0;
      dig_q  <= DIG_ONES;
      an_q   <= 3'b110;
      seg_q  <= SEG_0;
    end else begin
      scan_q <= (scan_q == SCAN_TC) ? 20'd0 : scan_q + 20'd1;
      dig_q  <= dig_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
    end
  end

  assign busy = (state_q == ST_CONV);
  assign seg  = seg_q;
  assign an   = an_q;
  assign dp_n = 1'b1;

endmodule

// File: tb/tb_addsub_result_display.sv
// Randomised self-checking bench for addsub_result_display with a fast scan rate.
module tb_addsub_result_display;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0;
  logic [4:0] S = '0;
  logic       sign = 1'b0;
  logic       busy;
  logic [6:0] seg;
  logic       dp_n;
  logic [2:0] an;

  int n_checks = 0;
  int n_fail   = 0;

  addsub_result_display #(.REFRESH_DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .S(S), .sign(sign),
    .busy(busy), .seg(seg), .dp_n(dp_n), .an(an)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] digit_code(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Reference: what each digit of the display should show for a magnitude/sign.
  function automatic void model(input int mag, input bit sg,
                                output logic [6:0] eo, output logic [6:0] et,
                                output logic [6:0] es);
    eo = digit_code(mag % 10);
    et = digit_code(mag / 10);
`ifdef BLANK_LEADING_ZERO_EN
    if (mag / 10 == 0) et = 7'b1111111;
`endif
    es = (sg && mag != 0) ? 7'b0111111 : 7'b1111111;
  endfunction

  // Called right after a negedge; returns the number of cycles busy stayed high.
  task automatic do_load(input logic [4:0] v, input logic sg, output int n);
    load = 1'b1; S = v; sign = sg;
    @(negedge clk);
    load = 1'b0; S = $urandom_range(31); sign = $urandom_range(1);
    n = 0;
    while (busy && n < 20) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Observes one full scan period and records each digit's segments.
  task automatic capture(output logic [6:0] o, output logic [6:0] t,
                         output logic [6:0] s, output bit ok);
    o = 'x; t = 'x; s = 'x; ok = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3 * DIV; i++) begin
      @(negedge clk);
      case (an)
        3'b110:  o = seg;
        3'b101:  t = seg;
        3'b011:  s = seg;
        default: ok = 1'b0;
      endcase
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n_checks += 4;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (an !== 3'b110) begin n_fail++; $display("FAIL reset_an got=%b exp=110", an); end
    if (seg !== 7'b1000000) begin n_fail++; $display("FAIL reset_seg got=%b exp=1000000", seg); end
    if (dp_n !== 1'b1) begin n_fail++; $display("FAIL reset_dp_n got=%b exp=1", dp_n); end
  endtask

  task automatic test_value(input string name, input logic [4:0] v, input logic sg);
    int n; bit ok;
    logic [6:0] o, t, s, eo, et, es;
    do_load(v, sg, n);
    capture(o, t, s, ok);
    model(v, sg, eo, et, es);
    n_checks += 5;
    if (n !== 5) begin n_fail++; $display("FAIL %s_busy_cycles S=%0d got=%0d exp=5", name, v, n); end
    if (o !== eo) begin n_fail++; $display("FAIL %s_ones S=%0d got=%b exp=%b", name, v, o, eo); end
    if (t !== et) begin n_fail++; $display("FAIL %s_tens S=%0d got=%b exp=%b", name, v, t, et); end
    if (s !== es) begin n_fail++; $display("FAIL %s_sign S=%0d sg=%b got=%b exp=%b", name, v, sg, s, es); end
    if (!ok) begin n_fail++; $display("FAIL %s_an_onehot got=0 exp=1", name); end
  endtask

  task automatic test_lockout();
    int n; bit ok;
    logic [6:0] o, t, s, eo, et, es;
    load = 1'b1; S = 5'd31; sign = 1'b0;
    @(negedge clk); load = 1'b0;
    @(negedge clk); load = 1'b1; S = 5'd5; sign = 1'b1;
    @(negedge clk); load = 1'b0;
    @(negedge clk);
    @(negedge clk); load = 1'b1; S = 5'd7; sign = 1'b1;
    @(negedge clk); load = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL lockout_e5_load got_busy=%b exp=0", busy); end
    capture(o, t, s, ok);
    model(31, 1'b0, eo, et, es);
    n_checks += 3;
    if (o !== eo) begin n_fail++; $display("FAIL lockout_ones got=%b exp=%b", o, eo); end
    if (t !== et) begin n_fail++; $display("FAIL lockout_tens got=%b exp=%b", t, et); end
    if (s !== es) begin n_fail++; $display("FAIL lockout_sign got=%b exp=%b", s, es); end
    do_load(5'd0, 1'b1, n);
    capture(o, t, s, ok);
    model(0, 1'b1, eo, et, es);
    n_checks += 3;
    if (n !== 5) begin n_fail++; $display("FAIL negzero_busy got=%0d exp=5", n); end
    if (o !== eo) begin n_fail++; $display("FAIL negzero_ones got=%b exp=%b", o, eo); end
    if (s !== es) begin n_fail++; $display("FAIL negzero_sign got=%b exp=%b", s, es); end
  endtask

  task automatic test_scan();
    logic [2:0] prev, cur, expn;
    int w;
    int bad;
    prev = an; w = 0;
    while (an === prev && w < 20) begin w++; @(negedge clk); end
    n_checks++;
    if (w >= 20) begin n_fail++; $display("FAIL scan_no_change got_an=%b", an); end
    cur = an; bad = 0;
    for (int k = 0; k < 6; k++) begin
      repeat (DIV - 1) begin
        @(negedge clk);
        if (an !== cur) bad++;
      end
      @(negedge clk);
      case (cur)
        3'b110:  expn = 3'b101;
        3'b101:  expn = 3'b011;
        default: expn = 3'b110;
      endcase
      n_checks++;
      if (an !== expn) begin n_fail++; $display("FAIL scan_step%0d got=%b exp=%b", k, an, expn); end
      cur = an;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL scan_hold got=%0d early_changes exp=0", bad); end
  endtask

  task automatic test_back_to_back();
    int n;
    do_load(5'd12, 1'b1, n);
    do_load(5'd27, 1'b0, n);
    n_checks++;
    if (n !== 5) begin n_fail++; $display("FAIL b2b_second_accept busy_cycles got=%0d exp=5", n); end
    test_value("b2b_follow", 5'd19, 1'b1);
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [6:0] o, t, s, eo, et, es;
    load = 1'b1; S = 5'd25; sign = 1'b1;
    @(negedge clk); load = 1'b0;
    @(negedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    n_checks += 3;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    if (an !== 3'b110) begin n_fail++; $display("FAIL midrst_an got=%b exp=110", an); end
    if (seg !== 7'b1000000) begin n_fail++; $display("FAIL midrst_seg got=%b exp=1000000", seg); end
    rst_n = 1'b1;
    capture(o, t, s, ok);
    model(0, 1'b0, eo, et, es);
    n_checks += 3;
    if (o !== eo) begin n_fail++; $display("FAIL midrst_ones got=%b exp=%b", o, eo); end
    if (t !== et) begin n_fail++; $display("FAIL midrst_tens got=%b exp=%b", t, et); end
    if (s !== es) begin n_fail++; $display("FAIL midrst_sign got=%b exp=%b", s, es); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++)
      test_value("rand", 5'($urandom_range(31)), 1'($urandom_range(1)));
  endtask

  initial begin
    test_reset();
    test_value("add", 5'd30, 1'b0);
    test_value("sub", 5'd4, 1'b1);
    test_lockout();
    test_scan();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
